input_vc_queue: RTL and testbench

Per-input-port virtual-channel buffer of the mesh VC router. It sits between the link input and the route-computation/switch-allocation stages. It stores incoming flits in one FIFO per VC and tracks per-VC packet state. It latches the destination X/Y of the head flit at each FIFO front and presents it registered, so route computation sees a stable address for the whole packet. It returns one credit per flit read.

---
 rtl/input_vc_queue_pkg.sv | 33 +++
 rtl/input_vc_queue_vc_fifo.sv | 53 +++++
 rtl/input_vc_queue.sv | 131 +++++++++++++
 tb/tb_input_vc_queue.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/input_vc_queue_pkg.sv
// input_vc_queue_pkg: flit type encodings, field positions, VC states and log2 helper
package input_vc_queue_pkg;

    localparam int TYPE_W     = 2;
    localparam int DEST_X_LSB = 0;

    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_TAIL   = 2'b01,
        FT_HEAD   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic {
        VC_IDLE   = 1'b0,
        VC_ROUTED = 1'b1
    } vc_state_e;

    function automatic int log2(input int n);
        int r = 0;
        for (int i = 0; i < 32; i++) r = ((1 << r) < n) ? r + 1 : r;
        return r;
    endfunction

    function automatic logic is_head(input flit_type_e t);
        return t == FT_HEAD || t == FT_SINGLE;
    endfunction

    function automatic logic is_tail(input flit_type_e t);
        return t == FT_TAIL || t == FT_SINGLE;
    endfunction

endpackage

// File: rtl/input_vc_queue_vc_fifo.sv
// vc_fifo: single-clock FIFO of depth B with combinational front flit and occupancy count
module vc_fifo
    import input_vc_queue_pkg::*;
#(
    parameter int B  = 4,
    parameter int FW = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_i,
    input  logic              rd_i,
    input  logic [FW-1:0]     din_i,
    output logic [FW-1:0]     front_o,
    output logic [log2(B):0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PW = log2(B);

    logic [FW-1:0] mem_q [B];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          we, re;

    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (PW+1)'(B);
    assign re      = rd_i & ~empty_o;
    // a full FIFO still accepts a write when the same edge pops a flit
    assign we      = wr_i & (~full_o | re);
    assign wp_d    = wp_q + PW'(we);
    assign rp_d    = rp_q + PW'(re);
    assign cnt_d   = cnt_q + (PW+1)'(we) - (PW+1)'(re);
    assign front_o = mem_q[rp_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[wp_q] <= din_i;
    end

endmodule

// File: rtl/input_vc_queue.sv
// input_vc_queue: per-port VC buffers with head-flit route latching and credit return.
// Define INPUT_VC_OVERFLOW_CHECK_EN to get sticky per-VC overflow flags.
module input_vc_queue
    import input_vc_queue_pkg::*;
#(
    parameter int V          = 4,
    parameter int B          = 4,
    parameter int FLIT_WIDTH = 32,
    parameter int X_NODE_NUM = 4,
    parameter int Y_NODE_NUM = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [FLIT_WIDTH-1:0]              flit_in,
    input  logic                               flit_in_we,
    input  logic [V-1:0]                       vc_num_in,
    input  logic [V-1:0]                       rd_vc,
    output logic [FLIT_WIDTH-1:0]              flit_out,
    output logic                               flit_out_valid,
    output logic [V-1:0]                       credit_out,
    output logic [V-1:0]                       vc_not_empty,
    output logic [V-1:0]                       route_valid,
    output logic [V*log2(X_NODE_NUM)-1:0]      dest_x_out,
    output logic [V*log2(Y_NODE_NUM)-1:0]      dest_y_out,
    output logic [V-1:0]                       overflow_err
);

    localparam int X_W = log2(X_NODE_NUM);
    localparam int Y_W = log2(Y_NODE_NUM);
    localparam int CW  = log2(B) + 1;

    logic [FLIT_WIDTH-1:0] front [V];
    logic [V-1:0]          full, empty, rd_ok, wr_sel, wr_acc;
    logic [FLIT_WIDTH-1:0] flit_out_d, flit_out_q;
    logic                  valid_q;
    logic [V-1:0]          credit_q;

    assign wr_sel = {V{flit_in_we}} & vc_num_in;
    assign rd_ok  = rd_vc & ~empty;
    assign wr_acc = wr_sel & (~full | rd_ok);

    for (genvar v = 0; v < V; v++) begin : g_vc
        vc_state_e      st_q, st_d;
        logic [X_W-1:0] dx_q, dx_d;
        logic [Y_W-1:0] dy_q, dy_d;
        logic [CW-1:0]  cnt;
        flit_type_e     ft;

        vc_fifo #(.B(B), .FW(FLIT_WIDTH)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .wr_i    (wr_acc[v]),
            .rd_i    (rd_ok[v]),
            .din_i   (flit_in),
            .front_o (front[v]),
            .count_o (cnt),
            .full_o  (full[v]),
            .empty_o (empty[v])
        );

        assign ft = flit_type_e'(front[v][FLIT_WIDTH-1 -: TYPE_W]);

        // route latches only from IDLE, so a back-to-back head waits one idle cycle
        always_comb begin
            st_d = st_q;
            dx_d = dx_q;
            dy_d = dy_q;
            if (st_q == VC_IDLE && !empty[v] && is_head(ft)) begin
                st_d = VC_ROUTED;
                dx_d = front[v][DEST_X_LSB +: X_W];
                dy_d = front[v][DEST_X_LSB + X_W +: Y_W];
            end else if (st_q == VC_ROUTED && rd_ok[v] && is_tail(ft)) begin
                st_d = VC_IDLE;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                st_q <= VC_IDLE;
                dx_q <= '0;
                dy_q <= '0;
            end else begin
                st_q <= st_d;
                dx_q <= dx_d;
                dy_q <= dy_d;
            end
        end

        assign vc_not_empty[v]           = cnt != '0;
        assign route_valid[v]            = st_q == VC_ROUTED;
        assign dest_x_out[v*X_W +: X_W]  = dx_q;
        assign dest_y_out[v*Y_W +: Y_W]  = dy_q;
    end

    always_comb begin
        flit_out_d = '0;
        for (int i = 0; i < V; i++) flit_out_d = flit_out_d | (rd_ok[i] ? front[i] : '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flit_out_q <= '0;
            valid_q    <= 1'b0;
            credit_q   <= '0;
        end else begin
            flit_out_q <= flit_out_d;
            valid_q    <= |rd_ok;
            credit_q   <= rd_ok;
        end
    end

    assign flit_out       = flit_out_q;
    assign flit_out_valid = valid_q;
    assign credit_out     = credit_q;

`ifdef INPUT_VC_OVERFLOW_CHECK_EN
    logic [V-1:0] ovf_q, ovf_d;

    assign ovf_d = ovf_q | (wr_sel & ~wr_acc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ovf_q <= '0;
        else        ovf_q <= ovf_d;
    end

    assign overflow_err = ovf_q;
`else
    assign overflow_err = '0;
`endif

endmodule

// File: tb/tb_input_vc_queue.sv
// tb_input_vc_queue: directed checks of VC buffering, routing FSM, credits, overflow and reset
module tb_input_vc_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] flit_in = '0;
    logic        flit_in_we = 1'b0;
    logic [3:0]  vc_num_in = '0;
    logic [3:0]  rd_vc = '0;
    logic [31:0] flit_out;
    logic        flit_out_valid;
    logic [3:0]  credit_out, vc_not_empty, route_valid, overflow_err;
    logic [7:0]  dest_x_out, dest_y_out;
    logic [3:0]  ovf_exp;
    logic [31:0] exp_q [4];
    int          total = 0;
    int          bad = 0;

    input_vc_queue #(.V(4), .B(4), .FLIT_WIDTH(32), .X_NODE_NUM(4), .Y_NODE_NUM(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .flit_in        (flit_in),
        .flit_in_we     (flit_in_we),
        .vc_num_in      (vc_num_in),
        .rd_vc          (rd_vc),
        .flit_out       (flit_out),
        .flit_out_valid (flit_out_valid),
        .credit_out     (credit_out),
        .vc_not_empty   (vc_not_empty),
        .route_valid    (route_valid),
        .dest_x_out     (dest_x_out),
        .dest_y_out     (dest_y_out),
        .overflow_err   (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] vc, input logic [31:0] f);
        flit_in = f;
        flit_in_we = 1'b1;
        vc_num_in = vc;
        step();
        flit_in = '0;
        flit_in_we = 1'b0;
        vc_num_in = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
`ifdef INPUT_VC_OVERFLOW_CHECK_EN
        ovf_exp = 4'b0010;
`else
        ovf_exp = 4'b0000;
`endif
        #12;
        check("rst_ne", vc_not_empty, 0);
        check("rst_rv", route_valid, 0);
        check("rst_valid", flit_out_valid, 0);
        check("rst_flit", flit_out, 0);
        check("rst_credit", credit_out, 0);
        check("rst_dx", dest_x_out, 0);
        check("rst_dy", dest_y_out, 0);
        check("rst_ovf", overflow_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();

        // single-flit packet on VC0
        wr(4'b0001, 32'hC000_0009);
        check("t1_ne", vc_not_empty, 4'b0001);
        check("t1_rv_early", route_valid, 0);
        step();
        check("t1_rv", route_valid, 4'b0001);
        check("t1_dx", dest_x_out, 8'h01);
        check("t1_dy", dest_y_out, 8'h02);
        rd_vc = 4'b0001;
        step();
        rd_vc = '0;
        check("t1_flit", flit_out, 32'hC000_0009);
        check("t1_valid", flit_out_valid, 1);
        check("t1_credit", credit_out, 4'b0001);
        check("t1_rv_drop", route_valid, 0);
        check("t1_ne_drop", vc_not_empty, 0);
        step();
        check("t1_valid_end", flit_out_valid, 0);

        // head/body/tail on VC2
        wr(4'b0100, 32'h8000_0006);
        wr(4'b0100, 32'h0000_0ABC);
        wr(4'b0100, 32'h4000_0DEF);
        check("t2_rv", route_valid, 4'b0100);
        check("t2_dx", dest_x_out, 8'h21);
        check("t2_dy", dest_y_out, 8'h12);
        rd_vc = 4'b0100;
        step();
        check("t2_head", flit_out, 32'h8000_0006);
        check("t2_cr0", credit_out, 4'b0100);
        check("t2_rv0", route_valid, 4'b0100);
        step();
        check("t2_body", flit_out, 32'h0000_0ABC);
        check("t2_cr1", credit_out, 4'b0100);
        step();
        rd_vc = '0;
        check("t2_tail", flit_out, 32'h4000_0DEF);
        check("t2_cr2", credit_out, 4'b0100);
        check("t2_rv_drop", route_valid, 0);
        step();
        check("t2_valid_end", flit_out_valid, 0);
        check("t2_ne", vc_not_empty, 0);

        // overflow on VC1
        exp_q = '{32'h8000_0005, 32'h0000_0001, 32'h0000_0002, 32'h4000_0003};
        for (int i = 0; i < 4; i++) wr(4'b0010, exp_q[i]);
        wr(4'b0010, 32'h0000_0BAD);
        check("t3_ne", vc_not_empty, 4'b0010);
        check("t3_ovf", overflow_err, ovf_exp);
        check("t3_rv", route_valid, 4'b0010);
        check("t3_dx", dest_x_out, 8'h25);
        check("t3_dy", dest_y_out, 8'h16);
        rd_vc = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("t3_pop%0d", i), flit_out, exp_q[i]);
            check($sformatf("t3_cr%0d", i), credit_out, 4'b0010);
        end
        check("t3_empty", vc_not_empty, 0);
        check("t3_rv_drop", route_valid, 0);
        step();
        rd_vc = '0;
        check("t3_empty_rd_valid", flit_out_valid, 0);
        check("t3_empty_rd_credit", credit_out, 0);
        check("t3_ovf_sticky", overflow_err, ovf_exp);

        // simultaneous read and write on full VC3
        exp_q = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h4000_0044};
        wr(4'b1000, 32'h8000_000F);
        for (int i = 0; i < 3; i++) wr(4'b1000, exp_q[i]);
        check("t4_rv", route_valid, 4'b1000);
        check("t4_dx", dest_x_out, 8'hE5);
        check("t4_dy", dest_y_out, 8'hD6);
        flit_in = exp_q[3];
        flit_in_we = 1'b1;
        vc_num_in = 4'b1000;
        rd_vc = 4'b1000;
        step();
        flit_in_we = 1'b0;
        vc_num_in = '0;
        check("t4_head", flit_out, 32'h8000_000F);
        check("t4_cr", credit_out, 4'b1000);
        check("t4_ovf", overflow_err, ovf_exp);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("t4_pop%0d", i), flit_out, exp_q[i]);
        end
        rd_vc = '0;
        check("t4_empty", vc_not_empty, 0);
        check("t4_rv_drop", route_valid, 0);

        // back-to-back packets on VC0
        wr(4'b0001, 32'h8000_0001);
        wr(4'b0001, 32'h4000_0000);
        wr(4'b0001, 32'hC000_000E);
        check("t5_rv", route_valid, 4'b0001);
        check("t5_dx", dest_x_out, 8'hE5);
        check("t5_dy", dest_y_out, 8'hD4);
        rd_vc = 4'b0001;
        step();
        check("t5_head", flit_out, 32'h8000_0001);
        step();
        rd_vc = '0;
        check("t5_tail", flit_out, 32'h4000_0000);
        check("t5_idle_rv", route_valid, 0);
        check("t5_idle_ne", vc_not_empty, 4'b0001);
        check("t5_idle_dx", dest_x_out, 8'hE5);
        step();
        check("t5_rv2", route_valid, 4'b0001);
        check("t5_dx2", dest_x_out, 8'hE6);
        check("t5_dy2", dest_y_out, 8'hD7);
        rd_vc = 4'b0001;
        step();
        rd_vc = '0;
        check("t5_single", flit_out, 32'hC000_000E);
        check("t5_rv_end", route_valid, 0);

        // reset mid-packet on VC1
        wr(4'b0010, 32'h8000_0005);
        wr(4'b0010, 32'h0000_0001);
        check("t6_rv", route_valid, 4'b0010);
        rd_vc = 4'b0010;
        step();
        rd_vc = '0;
        check("t6_flit", flit_out, 32'h8000_0005);
        #2;
        reset = 1'b0;
        #1;
        check("t6_flit_rst", flit_out, 0);
        check("t6_valid_rst", flit_out_valid, 0);
        check("t6_credit_rst", credit_out, 0);
        check("t6_ne_rst", vc_not_empty, 0);
        check("t6_rv_rst", route_valid, 0);
        check("t6_dx_rst", dest_x_out, 0);
        check("t6_dy_rst", dest_y_out, 0);
        check("t6_ovf_rst", overflow_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        check("t6_ne_rel", vc_not_empty, 0);
        wr(4'b0010, 32'h8000_000A);
        check("t6_ne_new", vc_not_empty, 4'b0010);
        check("t6_rv_new_early", route_valid, 0);
        step();
        check("t6_rv_new", route_valid, 4'b0010);
        check("t6_dx_new", dest_x_out, 8'h08);
        check("t6_dy_new", dest_y_out, 8'h08);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
